// File: rtl/n1_pbus_tgt_pkg.sv
// Shared types and sizes for the N1 program-bus target.
// The range-check option is controlled by N1_PBUS_TGT_RANGE_CHECK_EN (see n1_pbus_tgt).
package n1_pbus_tgt_pkg;

  localparam int QUEUE_DEPTH = 2;
  localparam int CNT_W       = 3;
  localparam int FILL_W      = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10
  } tgt_state_t;

endpackage

// File: rtl/n1_pbus_tgt_queue.sv
// Two-entry request FIFO for the program-bus target.
// Each entry is an opaque word; the top packs the address (and optional range flag) into it.
module n1_pbus_tgt_queue
  import n1_pbus_tgt_pkg::*;
#(
  parameter int ENTRY_W = 12
) (
  input  logic               clk_i,
  input  logic               async_rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [ENTRY_W-1:0] push_entry_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic [FILL_W-1:0]  fill_o,
  output logic [FILL_W-1:0]  fill_nxt_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  logic [ENTRY_W-1:0] entry_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   fill_d = fill_q + FILL_W'(1);
        2'b01:   fill_d = fill_q - FILL_W'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: entry storage is not reset; fill alone decides whether an entry is meaningful.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) entry_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o     = entry_q[rd_ptr_q];
  assign fill_o     = fill_q;
  assign fill_nxt_o = fill_d;

endmodule

// File: rtl/n1_pbus_tgt.sv
// Wishbone-pipelined program-bus target: 2-deep request queue, wait-state FSM, sync memory read.
// Define N1_PBUS_TGT_RANGE_CHECK_EN to answer out-of-range addresses with err instead of aliasing.
module n1_pbus_tgt
  import n1_pbus_tgt_pkg::*;
#(
  parameter  int PBUS_AADR_WIDTH = 16,
  parameter  int PBUS_DAT_WIDTH  = 16,
  parameter  int MEM_DEPTH       = 4096,
  parameter  int WAIT_CYCLES     = 0,
  localparam int MEM_AW          = $clog2(MEM_DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       async_rst_i,
  input  logic                       pbus_cyc_i,
  input  logic                       pbus_stb_i,
  input  logic [PBUS_AADR_WIDTH-1:0] pbus_adr_i,
  output logic                       pbus_ack_o,
  output logic                       pbus_err_o,
  output logic                       pbus_stall_o,
  output logic [PBUS_DAT_WIDTH-1:0]  pbus_dat_o,
  output logic                       mem_re_o,
  output logic [MEM_AW-1:0]          mem_adr_o,
  input  logic [PBUS_DAT_WIDTH-1:0]  mem_rdat_i,
  output logic [1:0]                 prb_tgt_state_o,
  output logic [2:0]                 prb_tgt_cnt_o,
  output logic [1:0]                 prb_tgt_fill_o
);

  localparam tgt_state_t       START_STATE = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
  localparam logic [CNT_W-1:0] WAIT_LOAD   = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  tgt_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic [PBUS_DAT_WIDTH-1:0] dat_q;
  logic                      mem_re;
  logic                      accept, pop, head_oor;
  logic [FILL_W-1:0]         fill, fill_nxt;
  logic [MEM_AW-1:0]         head_adr;

`ifdef N1_PBUS_TGT_RANGE_CHECK_EN
  localparam int ENTRY_W = MEM_AW + 1;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic               adr_oor;
  assign adr_oor    = 32'(pbus_adr_i) >= 32'(MEM_DEPTH);
  assign push_entry = {adr_oor, pbus_adr_i[MEM_AW-1:0]};
  assign head_oor   = head_entry[MEM_AW];
`else
  localparam int ENTRY_W = MEM_AW;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  // Without the range check the upper address bits are ignored, so addresses alias.
  assign push_entry = pbus_adr_i[MEM_AW-1:0];
  assign head_oor   = 1'b0;
  if (PBUS_AADR_WIDTH > MEM_AW) begin : g_adr_hi
    logic unused_adr_hi;
    assign unused_adr_hi = ^pbus_adr_i[PBUS_AADR_WIDTH-1:MEM_AW];
  end
`endif

  assign head_adr     = head_entry[MEM_AW-1:0];
  assign pbus_stall_o = (fill == FILL_W'(QUEUE_DEPTH));
  assign accept       = pbus_cyc_i & pbus_stb_i & ~pbus_stall_o;
  assign pop          = (state_q == ACCESS);

  n1_pbus_tgt_queue #(
    .ENTRY_W (ENTRY_W)
  ) u_queue (
    .clk_i        (clk_i),
    .async_rst_i  (async_rst_i),
    .push_i       (accept),
    .pop_i        (pop),
    .flush_i      (~pbus_cyc_i),
    .push_entry_i (push_entry),
    .head_o       (head_entry),
    .fill_o       (fill),
    .fill_nxt_o   (fill_nxt)
  );

  // Starting decisions look at the post-edge fill, so a request accepted this edge is served next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_nxt != '0) begin
          state_d = START_STATE;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ACCESS: begin
        if (head_oor) begin
          err_d = 1'b1;
        end else begin
          mem_re = 1'b1;
          ack_d  = 1'b1;
        end
        if (fill_nxt != '0) begin
          state_d = START_STATE;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping cyc abandons everything, including a response that would land next cycle.
    if (!pbus_cyc_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (pbus_ack_o) dat_q <= mem_rdat_i;
    end
  end

  // Memory data arrives in the response cycle; dat_q only keeps it visible afterwards.
  assign pbus_ack_o      = ack_q & pbus_cyc_i;
  assign pbus_err_o      = err_q & pbus_cyc_i;
  assign pbus_dat_o      = pbus_ack_o ? mem_rdat_i : dat_q;
  assign mem_re_o        = mem_re;
  assign mem_adr_o       = mem_re ? head_adr : '0;
  assign prb_tgt_state_o = state_q;
  assign prb_tgt_cnt_o   = cnt_q;
  assign prb_tgt_fill_o  = fill;

endmodule

// File: tb/tb_n1_pbus_tgt.sv
// Self-checking bench for n1_pbus_tgt: one instance with no wait states, one with three.
// Expected timing comes from a per-request service-time model rather than from the FSM.
module tb_n1_pbus_tgt;

  localparam int W0 = 0;
  localparam int W1 = 3;
`ifdef N1_PBUS_TGT_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef struct {
    int          t;
    logic [15:0] adr;
    logic        err;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc   [2];
  logic        stb   [2];
  logic [15:0] adr   [2];
  logic        ack   [2];
  logic        err   [2];
  logic        stall [2];
  logic [15:0] dat   [2];
  logic        mre   [2];
  logic [11:0] madr  [2];
  logic [1:0]  st    [2];
  logic [2:0]  cnt   [2];
  logic [1:0]  fill  [2];
  logic [15:0] rdat0, rdat1;

  logic [15:0] mem_img  [4096];
  logic [15:0] last_dat [2];
  int          edge_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(posedge clk) if (mre[0]) rdat0 <= mem_img[madr[0]];
  always @(posedge clk) if (mre[1]) rdat1 <= mem_img[madr[1]];

  n1_pbus_tgt #(.WAIT_CYCLES(W0)) u_dut0 (
    .clk_i (clk), .async_rst_i (rst_n),
    .pbus_cyc_i (cyc[0]), .pbus_stb_i (stb[0]), .pbus_adr_i (adr[0]),
    .pbus_ack_o (ack[0]), .pbus_err_o (err[0]), .pbus_stall_o (stall[0]), .pbus_dat_o (dat[0]),
    .mem_re_o (mre[0]), .mem_adr_o (madr[0]), .mem_rdat_i (rdat0),
    .prb_tgt_state_o (st[0]), .prb_tgt_cnt_o (cnt[0]), .prb_tgt_fill_o (fill[0])
  );

  n1_pbus_tgt #(.WAIT_CYCLES(W1)) u_dut1 (
    .clk_i (clk), .async_rst_i (rst_n),
    .pbus_cyc_i (cyc[1]), .pbus_stb_i (stb[1]), .pbus_adr_i (adr[1]),
    .pbus_ack_o (ack[1]), .pbus_err_o (err[1]), .pbus_stall_o (stall[1]), .pbus_dat_o (dat[1]),
    .mem_re_o (mre[1]), .mem_adr_o (madr[1]), .mem_rdat_i (rdat1),
    .prb_tgt_state_o (st[1]), .prb_tgt_cnt_o (cnt[1]), .prb_tgt_fill_o (fill[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int d);
    check($sformatf("d%0d_rst_ack", d),   ack[d],   0);
    check($sformatf("d%0d_rst_err", d),   err[d],   0);
    check($sformatf("d%0d_rst_stall", d), stall[d], 0);
    check($sformatf("d%0d_rst_dat", d),   dat[d],   0);
    check($sformatf("d%0d_rst_re", d),    mre[d],   0);
    check($sformatf("d%0d_rst_madr", d),  madr[d],  0);
    check($sformatf("d%0d_rst_state", d), st[d],    0);
    check($sformatf("d%0d_rst_cnt", d),   cnt[d],   0);
    check($sformatf("d%0d_rst_fill", d),  fill[d],  0);
  endtask

  function automatic logic [15:0] pick_adr(input int mode, input logic [15:0] base, input int k);
    case (mode)
      0:       return base + 16'(k);
      1:       return 16'($urandom_range(0, 4095));
      default: return ($urandom_range(0, 1) == 1) ? 16'($urandom_range(4096, 65535))
                                                   : 16'($urandom_range(0, 4095));
    endcase
  endfunction

  // Drive n requests into DUT d and check every cycle until all responses are back.
  // Request k finishes at max(accept + W + 2, previous finish + W + 1); it occupies a queue
  // slot until the edge before its response, and the memory is read in the cycle before that.
  task automatic stream(input int d, input int n, input int mode, input logic [15:0] base,
                        input bit gaps);
    req_t        pend[$];
    req_t        r;
    int          issued = 0;
    int          guard = 0;
    int          t, busy;
    int          last_resp = 0;
    int          wc = (d == 0) ? W0 : W1;
    logic [15:0] a;
    logic        exp_ack, exp_err, exp_re, exp_stall;
    logic [11:0] exp_madr;
    cyc[d] = 1'b1;
    a = pick_adr(mode, base, 0);
    while ((issued < n || pend.size() != 0) && guard < 400) begin
      @(negedge clk);
      guard++;
      t = edge_n + 1;
      exp_ack = 1'b0; exp_err = 1'b0; exp_re = 1'b0; exp_madr = '0; busy = 0;
      foreach (pend[i]) begin
        if (pend[i].t == t) begin
          exp_ack = !pend[i].err;
          exp_err = pend[i].err;
        end
        if (pend[i].t == t + 1 && !pend[i].err) begin
          exp_re   = 1'b1;
          exp_madr = pend[i].adr[11:0];
        end
        if (pend[i].t > t) busy++;
      end
      exp_stall = (busy == 2);
      check($sformatf("d%0d_ack@%0d", d, t), ack[d], exp_ack);
      check($sformatf("d%0d_err@%0d", d, t), err[d], exp_err);
      check($sformatf("d%0d_stall@%0d", d, t), stall[d], exp_stall);
      check($sformatf("d%0d_mem_re@%0d", d, t), mre[d], exp_re);
      if (exp_re) check($sformatf("d%0d_mem_adr@%0d", d, t), madr[d], exp_madr);
      if (exp_ack) last_dat[d] = mem_img[pend[0].adr[11:0]];
      check($sformatf("d%0d_dat@%0d", d, t), dat[d], last_dat[d]);
      if (pend.size() != 0 && pend[0].t == t) void'(pend.pop_front());
      if (issued < n && !(gaps && $urandom_range(0, 3) == 0)) begin
        stb[d] = 1'b1;
        adr[d] = a;
        if (!exp_stall) begin
          r.t   = (t + wc + 2 > last_resp + wc + 1) ? t + wc + 2 : last_resp + wc + 1;
          r.adr = a;
          r.err = RANGE_EN && (a >= 16'h1000);
          pend.push_back(r);
          last_resp = r.t;
          issued++;
          a = pick_adr(mode, base, issued);
        end
      end else begin
        stb[d] = 1'b0;
      end
    end
    stb[d] = 1'b0;
    check($sformatf("d%0d_stream_timeout", d), 32'(guard >= 400), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; adr[i] = '0; last_dat[i] = '0;
    end
    for (int i = 0; i < 4096; i++) mem_img[i] = 16'($urandom);
    mem_img[16] = 16'hA5C3;

    @(negedge clk);
    check_zero(0);
    check_zero(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read, streaming reads, wait-state reads, boundary address.
    stream(0, 1, 0, 16'h0010, 1'b0);
    check("d0_single_dat_A5C3", dat[0], 16'hA5C3);
    stream(0, 8, 0, 16'h0000, 1'b0);
    stream(1, 4, 0, 16'h0100, 1'b0);
    stream(0, 1, 0, 16'h1000, 1'b0);
    stream(1, 1, 0, 16'h1000, 1'b0);

    // cyc drop with two requests waiting on the W=3 target.
    @(negedge clk); stb[1] = 1'b1; adr[1] = 16'h0020;
    @(negedge clk); adr[1] = 16'h0021;
    @(negedge clk); stb[1] = 1'b0;
    check("d1_flush_fill_before", fill[1], 2);
    check("d1_flush_stall_before", stall[1], 1);
    cyc[1] = 1'b0;
    #1;
    check("d1_flush_ack_low", ack[1], 0);
    check("d1_flush_err_low", err[1], 0);
    @(negedge clk);
    check("d1_flush_fill", fill[1], 0);
    check("d1_flush_state", st[1], 0);
    check("d1_flush_cnt", cnt[1], 0);
    cyc[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("d1_flush_no_ack", ack[1], 0);
      check("d1_flush_no_err", err[1], 0);
      check("d1_flush_no_re", mre[1], 0);
    end
    stream(1, 1, 1, 16'h0000, 1'b0);

    // cyc drop on the W=0 target while a response is due.
    @(negedge clk); stb[0] = 1'b1; adr[0] = 16'h0030;
    @(negedge clk); adr[0] = 16'h0031;
    @(negedge clk); stb[0] = 1'b0; cyc[0] = 1'b0;
    #1;
    check("d0_flush_ack_low", ack[0], 0);
    check("d0_flush_err_low", err[0], 0);
    check("d0_flush_dat_hold", dat[0], last_dat[0]);
    @(negedge clk);
    check("d0_flush_ack_next", ack[0], 0);
    check("d0_flush_fill", fill[0], 0);
    check("d0_flush_state", st[0], 0);
    cyc[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("d0_flush_no_ack", ack[0], 0);
    end
    stream(0, 1, 1, 16'h0000, 1'b0);

    // Asynchronous reset in the middle of a wait with a full queue.
    @(negedge clk); stb[1] = 1'b1; adr[1] = 16'h0040;
    @(negedge clk); adr[1] = 16'h0041;
    @(negedge clk); stb[1] = 1'b0;
    check("d1_pre_rst_state", st[1], 1);
    check("d1_pre_rst_fill", fill[1], 2);
    check("d1_pre_rst_cnt", cnt[1], 1);
    #2 rst_n = 1'b0;
    #1;
    last_dat[0] = '0;
    last_dat[1] = '0;
    check_zero(0);
    check_zero(1);
    @(negedge clk);
    rst_n = 1'b1;
    stream(1, 1, 1, 16'h0000, 1'b0);
    stream(0, 1, 1, 16'h0000, 1'b0);

    // Randomized traffic, including out-of-range addresses and idle gaps.
    stream(0, 20, 2, 16'h0000, 1'b1);
    stream(1, 12, 2, 16'h0000, 1'b1);
    stream(0, 16, 1, 16'h0000, 1'b0);
    stream(1, 8, 1, 16'h0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
